// File: rtl/m_cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   XLEN          - datapath width
//   INST_NOP      - canonical no-op encoding (addi x0, x0, 0)
//   fetch_state_e - fetch control states
//   fetch_entry_t - one buffered instruction with its PC
//   align_pc()    - clears the byte-offset bits of a fetch address
package m_cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRedir
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// Small instruction buffer between imem response and decode.
//   w_clk, w_rst : clock, async active-high reset
//   push_i       : write entry_i at the tail
//   pop_i        : drop the head entry
//   flush_i      : discard all entries; wins over push_i
//   entry_i      : {pc, inst} to enqueue
//   count_o      : current occupancy (0..DEPTH)
//   head_o       : head entry; only meaningful when count_o != 0
module m_fetch_fifo
  import m_cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             entry_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wptr_q, rptr_q;
  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the consumer masks the head while empty.
  always_ff @(posedge w_clk) begin
    if (push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= entry_i;
  end

  assign count_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/m_fetch.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// imem, buffers {inst, pc} pairs and hands them to execute over valid/ready.
// Redirects from execute flush the buffer and squash the outstanding read.
//   w_clk, w_rst          : clock, async active-high reset
//   w_imem_req/addr       : read strobe and word address (pc[IMEM_AW+1:2])
//   w_imem_rdata          : read data, one cycle after w_imem_req
//   w_redirect_valid/pc   : new fetch target (byte offset bits ignored)
//   w_inst_valid/inst/pc  : buffered head instruction, zero while empty
//   w_inst_ready          : consumer takes the head this cycle
// Optional: define FETCH_PERF_EN to add saturating counters
//   w_perf_fetched (handshakes) and w_perf_squashed (discarded fetches).
module m_fetch
  import m_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned IMEM_AW  = 6,
  parameter int unsigned DEPTH    = 2
) (
  input  logic               w_clk,
  input  logic               w_rst,
  output logic               w_imem_req,
  output logic [IMEM_AW-1:0] w_imem_addr,
  input  logic [31:0]        w_imem_rdata,
  input  logic               w_redirect_valid,
  input  logic [31:0]        w_redirect_pc,
  output logic               w_inst_valid,
  output logic [31:0]        w_inst,
  output logic [31:0]        w_inst_pc,
  input  logic               w_inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        w_perf_fetched,
  output logic [31:0]        w_perf_squashed
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            inflight_q;
  logic [XLEN-1:0] inflight_pc_q;

  logic            pop, push, flush, issue;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   occ;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_in;

  assign pop   = w_inst_valid & w_inst_ready;
  // A response landing in a redirect cycle belongs to the wrong path.
  assign push  = inflight_q & ~w_redirect_valid;
  assign flush = w_redirect_valid;

  // Occupancy counting the outstanding read and the slot freed this cycle.
  assign occ   = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};
  assign issue = (state_q != StIdle) & ~w_redirect_valid & (occ < DepthOcc);

  assign fifo_in = '{pc: inflight_pc_q, inst: w_imem_rdata};

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= StRun;
        StRun:   if (w_redirect_valid) state_q <= StRedir;
        StRedir: state_q <= StRun;
        default: state_q <= StIdle;
      endcase
      // The latest redirect always wins over any sequential advance.
      if (w_redirect_valid) begin
        pc_q <= align_pc(w_redirect_pc);
      end else if (issue) begin
        pc_q <= pc_q + 32'd4;
      end
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
    end
  end

  m_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .entry_i (fifo_in),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign w_imem_req   = issue;
  assign w_imem_addr  = pc_q[IMEM_AW+1:2];
  assign w_inst_valid = (fifo_count != '0);
  assign w_inst       = w_inst_valid ? fifo_head.inst : '0;
  assign w_inst_pc    = w_inst_valid ? fifo_head.pc : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_squashed_q;
  logic [31:0] squash_delta;
  logic [32:0] squash_sum;

  // Entries still buffered after this cycle's handshake, plus the dropped response.
  always_comb begin
    squash_delta = '0;
    if (flush) begin
      squash_delta = 32'(fifo_count - CntW'(pop)) + 32'(inflight_q);
    end
    squash_sum = {1'b0, perf_squashed_q} + {1'b0, squash_delta};
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      perf_fetched_q  <= '0;
      perf_squashed_q <= '0;
    end else begin
      if (pop && (perf_fetched_q != 32'hFFFF_FFFF)) perf_fetched_q <= perf_fetched_q + 32'd1;
      perf_squashed_q <= squash_sum[32] ? 32'hFFFF_FFFF : squash_sum[31:0];
    end
  end

  assign w_perf_fetched  = perf_fetched_q;
  assign w_perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_m_fetch.sv
module tb_m_fetch;

  logic               w_clk = 1'b0;
  logic               w_rst = 1'b1;
  logic               w_imem_req;
  logic [5:0]         w_imem_addr;
  logic [31:0]        w_imem_rdata = '0;
  logic               w_redirect_valid = 1'b0;
  logic [31:0]        w_redirect_pc = '0;
  logic               w_inst_valid;
  logic [31:0]        w_inst;
  logic [31:0]        w_inst_pc;
  logic               w_inst_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0]        w_perf_fetched;
  logic [31:0]        w_perf_squashed;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [64];

  always #5 w_clk = ~w_clk;

  // Synchronous instruction memory, word k holds k + 1.
  always @(posedge w_clk) begin
    if (w_imem_req) w_imem_rdata <= imem[w_imem_addr];
  end

  m_fetch #(
    .RESET_PC (32'd0),
    .IMEM_AW  (6),
    .DEPTH    (2)
  ) dut (
    .w_clk            (w_clk),
    .w_rst            (w_rst),
    .w_imem_req       (w_imem_req),
    .w_imem_addr      (w_imem_addr),
    .w_imem_rdata     (w_imem_rdata),
    .w_redirect_valid (w_redirect_valid),
    .w_redirect_pc    (w_redirect_pc),
    .w_inst_valid     (w_inst_valid),
    .w_inst           (w_inst),
    .w_inst_pc        (w_inst_pc),
    .w_inst_ready     (w_inst_ready)
`ifdef FETCH_PERF_EN
    ,
    .w_perf_fetched   (w_perf_fetched),
    .w_perf_squashed  (w_perf_squashed)
`endif
  );

  // Advance one clock; outputs are sampled 2 time units after the edge.
  task automatic step();
    @(posedge w_clk);
    #2;
  endtask

  task automatic reset_dut();
    w_rst = 1'b1;
    w_redirect_valid = 1'b0;
    step();
    w_rst = 1'b0;
  endtask

  task automatic test_reset();
    w_rst = 1'b1;
    w_inst_ready = 1'b0;
    step();
    checks++;
    if (w_imem_req !== 1'b0 || w_inst_valid !== 1'b0 || w_inst !== 32'd0 || w_inst_pc !== 32'd0)
    begin
      errors++;
      $display("FAIL reset_outputs: got req=%b valid=%b inst=%h pc=%h, expected all zero",
               w_imem_req, w_inst_valid, w_inst, w_inst_pc);
    end
    w_rst = 1'b0;
  endtask

  // Called straight after test_reset: latency 3 edges then 1/cycle.
  task automatic test_stream();
    w_inst_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (w_inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_latency%0d: got valid=%b expected 0", i, w_inst_valid);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'(4 * i) || w_inst !== 32'(i + 1)) begin
        errors++;
        $display("FAIL stream_beat%0d: got valid=%b pc=%h inst=%h expected 1 %h %h",
                 i, w_inst_valid, w_inst_pc, w_inst, 32'(4 * i), 32'(i + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    w_inst_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'h0 || w_inst !== 32'h1 || w_imem_req !== 1'b0)
      begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b pc=%h inst=%h req=%b expected 1 0 1 0",
                 i, w_inst_valid, w_inst_pc, w_inst, w_imem_req);
      end
    end
    // Two entries held: popping one frees space for pc 8.
    w_inst_ready = 1'b1;
    #1;
    checks++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 6'd2) begin
      errors++;
      $display("FAIL stall_resume_issue: got req=%b addr=%0d expected 1 2", w_imem_req, w_imem_addr);
    end
    for (int i = 1; i < 4; i++) begin
      step();
      checks++;
      if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'(4 * i) || w_inst !== 32'(i + 1)) begin
        errors++;
        $display("FAIL stall_resume%0d: got valid=%b pc=%h inst=%h expected 1 %h %h",
                 i, w_inst_valid, w_inst_pc, w_inst, 32'(4 * i), 32'(i + 1));
      end
    end
  endtask

  task automatic test_redirect();
    reset_dut();
    w_inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'h8) begin
      errors++;
      $display("FAIL redir_pre: got valid=%b pc=%h expected 1 00000008", w_inst_valid, w_inst_pc);
    end
    w_redirect_valid = 1'b1;
    w_redirect_pc = 32'h40;
    #1;
    checks++;
    if (w_imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_no_issue: got req=%b expected 0", w_imem_req);
    end
    step();
    w_redirect_valid = 1'b0;
    #1;
    checks++;
    if (w_inst_valid !== 1'b0 || w_imem_req !== 1'b1 || w_imem_addr !== 6'h10) begin
      errors++;
      $display("FAIL redir_issue: got valid=%b req=%b addr=%h expected 0 1 10",
               w_inst_valid, w_imem_req, w_imem_addr);
    end
    step();
    checks++;
    if (w_inst_valid !== 1'b0 || w_imem_req !== 1'b1 || w_imem_addr !== 6'h11) begin
      errors++;
      $display("FAIL redir_squash: got valid=%b req=%b addr=%h expected 0 1 11",
               w_inst_valid, w_imem_req, w_imem_addr);
    end
    step();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'h40 || w_inst !== 32'd17) begin
      errors++;
      $display("FAIL redir_target: got valid=%b pc=%h inst=%h expected 1 00000040 00000011",
               w_inst_valid, w_inst_pc, w_inst);
    end
    step();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'h44 || w_inst !== 32'd18) begin
      errors++;
      $display("FAIL redir_next: got valid=%b pc=%h inst=%h expected 1 00000044 00000012",
               w_inst_valid, w_inst_pc, w_inst);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    w_inst_ready = 1'b1;
    w_redirect_valid = 1'b1;
    w_redirect_pc = 32'h20;
    step();
    w_redirect_pc = 32'h30;
    step();
    w_redirect_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (w_inst_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || w_inst_pc !== 32'h30 || w_inst !== 32'd13) begin
      errors++;
      $display("FAIL b2b_first: got seen=%b pc=%h inst=%h expected 1 00000030 0000000d",
               seen, w_inst_pc, w_inst);
    end
    step();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'h34 || w_inst !== 32'd14) begin
      errors++;
      $display("FAIL b2b_next: got valid=%b pc=%h inst=%h expected 1 00000034 0000000e",
               w_inst_valid, w_inst_pc, w_inst);
    end
  endtask

  task automatic test_misaligned();
    w_redirect_valid = 1'b1;
    w_redirect_pc = 32'h1B;
    step();
    w_redirect_valid = 1'b0;
    #1;
    checks++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 6'd6) begin
      errors++;
      $display("FAIL misalign_addr: got req=%b addr=%0d expected 1 6", w_imem_req, w_imem_addr);
    end
    step();
    step();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'h18 || w_inst !== 32'd7) begin
      errors++;
      $display("FAIL misalign_out: got valid=%b pc=%h inst=%h expected 1 00000018 00000007",
               w_inst_valid, w_inst_pc, w_inst);
    end
  endtask

  // Top word of imem followed by a wrap back to word 0.
  task automatic test_wrap();
    w_redirect_valid = 1'b1;
    w_redirect_pc = 32'hFC;
    step();
    w_redirect_valid = 1'b0;
    #1;
    checks++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 6'd63) begin
      errors++;
      $display("FAIL wrap_addr_top: got req=%b addr=%0d expected 1 63", w_imem_req, w_imem_addr);
    end
    step();
    checks++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 6'd0) begin
      errors++;
      $display("FAIL wrap_addr_zero: got req=%b addr=%0d expected 1 0", w_imem_req, w_imem_addr);
    end
    step();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'hFC || w_inst !== 32'd64) begin
      errors++;
      $display("FAIL wrap_top: got valid=%b pc=%h inst=%h expected 1 000000fc 00000040",
               w_inst_valid, w_inst_pc, w_inst);
    end
    step();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'h100 || w_inst !== 32'd1) begin
      errors++;
      $display("FAIL wrap_next: got valid=%b pc=%h inst=%h expected 1 00000100 00000001",
               w_inst_valid, w_inst_pc, w_inst);
    end
  endtask

  task automatic test_async_reset();
    w_inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (w_inst_valid !== 1'b1 || w_imem_req !== 1'b0) begin
      errors++;
      $display("FAIL areset_full: got valid=%b req=%b expected 1 0", w_inst_valid, w_imem_req);
    end
    #1;
    w_rst = 1'b1;
    #1;
    checks++;
    if (w_inst_valid !== 1'b0 || w_inst !== 32'd0 || w_inst_pc !== 32'd0 || w_imem_req !== 1'b0)
    begin
      errors++;
      $display("FAIL areset_now: got valid=%b inst=%h pc=%h req=%b expected all zero",
               w_inst_valid, w_inst, w_inst_pc, w_imem_req);
    end
    #1;
    w_rst = 1'b0;
    w_inst_ready = 1'b1;
    step();
    step();
    checks++;
    if (w_inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_latency: got valid=%b expected 0", w_inst_valid);
    end
    step();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'd0 || w_inst !== 32'd1) begin
      errors++;
      $display("FAIL areset_first: got valid=%b pc=%h inst=%h expected 1 00000000 00000001",
               w_inst_valid, w_inst_pc, w_inst);
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) imem[k] = 32'(k + 1);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
